// File: rtl/letter_spawner.sv
// Falling-letter record generator: a period timer triggers a bounded LFSR draw of
// (ch, speed, y), which is then offered to the object allocator over valid/ready.
module letter_spawner #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 'hACE1,
  parameter int                Y_W       = 10,
  parameter int                Y_MAX     = 640,
  parameter int                SPEED_W   = 4,
  parameter int                SPEED_MAX = 15,
  parameter int                MAX_DRAW  = 4,
  parameter bit                NO_REPEAT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [15:0]        period,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [7:0]         ch,
  output logic [SPEED_W-1:0] speed,
  output logic [8:0]         x,
  output logic [Y_W-1:0]     y,
  output logic [7:0]         dropped
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_OFFER = 2'd2;

  localparam int                 ATT_W   = $clog2(MAX_DRAW + 1);
  localparam logic [ATT_W-1:0]   ATT_MAX = ATT_W'(MAX_DRAW);
  localparam logic [LFSR_W-1:0]  SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [LFSR_W-1:0]  TAPS    = LFSR_W'(16'hB400);
  localparam logic [Y_W:0]       YMAX_L  = (Y_W+1)'(Y_MAX);
  localparam logic [SPEED_W-1:0] SMAX    = SPEED_W'(SPEED_MAX);

  function automatic logic [5:0] set_size(input logic [1:0] m);
    case (m)
      2'd2:    return 6'd10;
      2'd3:    return 6'd36;
      default: return 6'd26;
    endcase
  endfunction

  function automatic logic [7:0] ch_of(input logic [1:0] m, input logic [5:0] i);
    case (m)
      2'd1:    return 8'd65 + {2'b00, i};
      2'd2:    return 8'd48 + {2'b00, i};
      2'd3:    return (i < 6'd26) ? 8'd97 + {2'b00, i} : 8'd22 + {2'b00, i};
      default: return 8'd97 + {2'b00, i};
    endcase
  endfunction

  logic [LFSR_W-1:0]  lfsr;
  logic [15:0]        cnt, per_q, per_eff;
  logic [1:0]         state;
  logic [ATT_W-1:0]   att;
  logic [7:0]         last_ch;
  logic               tick, hs, drop;

  logic [Y_W-1:0]     raw_y, fix_y;
  logic [5:0]         raw_c, sz, idx, nxt_idx, fix_idx;
  logic [SPEED_W-1:0] raw_s, spd;
  logic [7:0]         cand_ch;
  logic               y_ok, rep, final_att;

  assign per_eff = (period == 16'd0) ? 16'd1 : period;
  assign tick    = enable && (cnt == per_q - 16'd1);
  assign hs      = spawn_valid && spawn_ready;
  assign drop    = tick && ((state == S_DRAW) || ((state == S_OFFER) && !hs));
  assign x       = 9'd0;

  always_comb begin
    raw_y     = lfsr[Y_W-1:0];
    raw_c     = lfsr[15:10];
    raw_s     = lfsr[SPEED_W-1:0];
    sz        = set_size(mode);
    idx       = raw_c % sz;
    cand_ch   = ch_of(mode, idx);
    y_ok      = {1'b0, raw_y} < YMAX_L;
    rep       = NO_REPEAT && (cand_ch == last_ch);
    final_att = (y_ok && !rep) || (att == ATT_MAX);
    // Fallback on the last attempt: fold y into range, step ch past the repeat
    fix_y     = y_ok ? raw_y : Y_W'({1'b0, raw_y} - YMAX_L);
    nxt_idx   = idx + 6'd1;
    fix_idx   = rep ? ((nxt_idx == sz) ? 6'd0 : nxt_idx) : idx;
    if (raw_s == '0)       spd = SPEED_W'(1);
    else if (raw_s > SMAX) spd = SMAX;
    else                   spd = raw_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= SEED_NZ;
      cnt         <= 16'd0;
      per_q       <= per_eff;
      state       <= S_IDLE;
      att         <= ATT_W'(1);
      last_ch     <= 8'd0;
      spawn_valid <= 1'b0;
      ch          <= 8'd97;
      speed       <= SPEED_W'(1);
      y           <= '0;
      dropped     <= 8'd0;
    end else begin
      lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
      if (enable) begin
        if (tick) begin
          cnt   <= 16'd0;
          per_q <= per_eff;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
      if (drop && dropped != 8'hFF) dropped <= dropped + 8'd1;
      case (state)
        S_IDLE: if (tick) begin
          state <= S_DRAW;
          att   <= ATT_W'(1);
        end
        S_DRAW: if (final_att) begin
          ch          <= ch_of(mode, fix_idx);
          y           <= fix_y;
          speed       <= spd;
          spawn_valid <= 1'b1;
          state       <= S_OFFER;
        end else begin
          att <= att + ATT_W'(1);
        end
        S_OFFER: if (hs) begin
          spawn_valid <= 1'b0;
          last_ch     <= ch;
          state       <= tick ? S_DRAW : S_IDLE;
          att         <= ATT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_letter_spawner.sv
// Bench for letter_spawner: segment table + randomized ready against a record-level
// reference model, plus backpressure and reset-during-offer sequences.
module tb_letter_spawner;
  localparam int MAX_DRAW = 4;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, spawn_ready = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] period = 16'd8;
  logic        v1, v2;
  logic [7:0]  ch1, ch2, dr1, dr2;
  logic [3:0]  sp1, sp2;
  logic [8:0]  x1, x2;
  logic [9:0]  y1, y2;

  letter_spawner dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period(period),
    .spawn_ready(spawn_ready), .spawn_valid(v1), .ch(ch1), .speed(sp1),
    .x(x1), .y(y1), .dropped(dr1));

  letter_spawner #(.SPEED_MAX(10)) dut10 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period(period),
    .spawn_ready(spawn_ready), .spawn_valid(v2), .ch(ch2), .speed(sp2),
    .x(x2), .y(y2), .dropped(dr2));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_cnt, m_per, m_rem, m_ch, m_y, m_raw_s, m_dropped, m_last;
  bit          m_valid, m_draw;
  logic [15:0] m_lfsr;
  int          p_ch, p_y, p_raw_s;
  int          cov_s0 = 0, cov_shi = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int size_of(input int md);
    return (md == 2) ? 10 : (md == 3) ? 36 : 26;
  endfunction

  function automatic int ch_map(input int md, input int idx);
    case (md)
      1:       return 65 + idx;
      2:       return 48 + idx;
      3:       return (idx < 26) ? 97 + idx : 48 + idx - 26;
      default: return 97 + idx;
    endcase
  endfunction

  function automatic int clamp(input int r, input int mx);
    return (r == 0) ? 1 : (r > mx) ? mx : r;
  endfunction

  // Whole record decided at tick time by looking ahead in the LFSR sequence
  task automatic plan_record();
    logic [15:0] v;
    int yv, idx, c, sz;
    bit ok, rep;
    v = m_lfsr;
    sz = size_of(int'(mode));
    for (int j = 1; j <= MAX_DRAW; j++) begin
      v   = lfsr_next(v);
      yv  = int'(v[9:0]);
      idx = int'(v[15:10]) % sz;
      c   = ch_map(int'(mode), idx);
      rep = (c == m_last);
      ok  = (yv < 640) && !rep;
      if (ok || j == MAX_DRAW) begin
        if (yv >= 640) yv -= 640;
        if (rep) c = ch_map(int'(mode), (idx + 1) % sz);
        p_ch = c; p_y = yv; p_raw_s = int'(v[3:0]); m_rem = j;
        break;
      end
    end
  endtask

  task automatic model_step();
    bit tk, hs, pre_draw, pre_valid;
    if (rst) begin
      m_cnt = 0; m_per = (period == 0) ? 1 : int'(period);
      m_lfsr = 16'hACE1; m_valid = 0; m_draw = 0; m_rem = 0;
      m_ch = 97; m_y = 0; m_raw_s = 1; m_dropped = 0; m_last = 0;
      return;
    end
    tk = enable && (m_cnt == m_per - 1);
    hs = m_valid && spawn_ready;
    pre_draw = m_draw; pre_valid = m_valid;
    if (enable) begin
      if (tk) begin m_cnt = 0; m_per = (period == 0) ? 1 : int'(period); end
      else m_cnt++;
    end
    if (pre_draw) begin
      m_rem--;
      if (m_rem == 0) begin
        m_draw = 0; m_valid = 1; m_ch = p_ch; m_y = p_y; m_raw_s = p_raw_s;
        if (p_raw_s == 0) cov_s0++;
        if (p_raw_s > 10) cov_shi++;
      end
    end
    if (hs) begin m_valid = 0; m_last = m_ch; end
    if (tk) begin
      if (!pre_draw && (!pre_valid || hs)) begin plan_record(); m_draw = 1; end
      else if (m_dropped < 255) m_dropped++;
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare();
    chk("valid",   int'(v1),  int'(m_valid));
    chk("ch",      int'(ch1), m_ch);
    chk("y",       int'(y1),  m_y);
    chk("speed",   int'(sp1), clamp(m_raw_s, 15));
    chk("x",       int'(x1),  0);
    chk("dropped", int'(dr1), m_dropped);
    chk("valid10", int'(v2),  int'(m_valid));
    chk("ch10",    int'(ch2), m_ch);
    chk("speed10", int'(sp2), clamp(m_raw_s, 10));
    chk("dropped10", int'(dr2), m_dropped);
  endtask

  // ---------------- per-record checks from the segment table ----------------
  bit rec_on = 0, have_prev = 0;
  int cur_lo, cur_hi, cur_lo2, cur_hi2, prev_acc;

  task automatic rec_check(input int c, input int yv);
    chk("ch_in_set", int'((c >= cur_lo && c <= cur_hi) || (c >= cur_lo2 && c <= cur_hi2)), 1);
    chk("y_lt_max", int'(yv < 640), 1);
    if (have_prev) chk("no_repeat", int'(c != prev_acc), 1);
    prev_acc = c; have_prev = 1;
  endtask

  task automatic cyc();
    bit hs;
    int c, yv;
    hs = (v1 === 1'b1) && spawn_ready;
    c = int'(ch1); yv = int'(y1);
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (hs && rec_on) rec_check(c, yv);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
    have_prev = 0;
  endtask

  typedef struct {
    bit en; int md; int per; int rdy_pct; int cycles;
    int lo; int hi; int lo2; int hi2;
  } seg_t;

  seg_t segs[$];
  int d0, n, cap_ch, cap_y;
  bit cap;

  initial begin
    segs = '{
      '{1, 0, 8,   100, 200, 97, 122, 97, 122},
      '{1, 1, 5,   70,  200, 65, 90,  65, 90},
      '{1, 2, 8,   100, 420, 48, 57,  48, 57},
      '{1, 2, 3,   50,  300, 48, 57,  48, 57},
      '{1, 3, 2,   80,  300, 97, 122, 48, 57},
      '{0, 3, 4,   40,  60,  97, 122, 48, 57},
      '{1, 0, 0,   60,  200, 97, 122, 97, 122},
      '{1, 1, 1,   10,  400, 65, 90,  65, 90}
    };

    do_reset(3);
    chk("rst_valid",   int'(v1),  0);
    chk("rst_ch",      int'(ch1), 97);
    chk("rst_speed",   int'(sp1), 1);
    chk("rst_y",       int'(y1),  0);
    chk("rst_dropped", int'(dr1), 0);

    rec_on = 1;
    foreach (segs[i]) begin
      // Let any in-flight draw finish and be taken before switching mode
      enable = 1'b0; spawn_ready = 1'b1;
      repeat (8) cyc();
      mode = 2'(segs[i].md); period = 16'(segs[i].per);
      cur_lo = segs[i].lo; cur_hi = segs[i].hi; cur_lo2 = segs[i].lo2; cur_hi2 = segs[i].hi2;
      enable = segs[i].en;
      for (int k = 0; k < segs[i].cycles; k++) begin
        spawn_ready = ($urandom_range(0, 99) < segs[i].rdy_pct);
        cyc();
      end
    end
    chk("dropped_saturated", int'(dr1), 255);
    chk("cov_speed_zero", int'(cov_s0 > 0), 1);
    chk("cov_speed_over10", int'(cov_shi > 0), 1);
    rec_on = 0;

    // Backpressure: 40 stalled cycles at period 8 span five ticks, four lost
    enable = 1'b1; mode = 2'd0; period = 16'd8; spawn_ready = 1'b1;
    do_reset(3);
    n = 0;
    while (v1 !== 1'b1 && n < 50) begin cyc(); n++; end
    chk("bp_first_offer", int'(v1), 1);
    cyc();
    spawn_ready = 1'b0;
    d0 = int'(dr1); cap = 0; cap_ch = 0; cap_y = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (v1 === 1'b1 && !cap) begin cap = 1; cap_ch = int'(ch1); cap_y = int'(y1); end
    end
    chk("bp_valid_held", int'(v1), 1);
    chk("bp_ch_stable", int'(ch1), cap_ch);
    chk("bp_y_stable", int'(y1), cap_y);
    chk("bp_dropped", int'(dr1) - d0, 4);
    spawn_ready = 1'b1;
    cyc();
    chk("bp_accepted", int'(v1), 0);

    // Reset while an offer is pending
    spawn_ready = 1'b0;
    n = 0;
    while (v1 !== 1'b1 && n < 30) begin cyc(); n++; end
    chk("ro_offer", int'(v1), 1);
    cyc();
    rst = 1'b1; spawn_ready = 1'b1;
    cyc();
    chk("ro_valid_dropped", int'(v1), 0);
    chk("ro_ch_reset", int'(ch1), 97);
    rst = 1'b0;
    repeat (40) begin
      spawn_ready = $urandom_range(0, 1);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
